// File: rtl/demux1to32_loader.sv
// Serial-to-parallel frame loader: distributes 32 handshaked words into 32
// holding registers and holds the completed frame until the consumer acks it.
module demux1to32_loader #(
  parameter int DATA_LENGTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_LENGTH-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  input  logic                   frame_ack,
  output logic                   frame_valid,
  output logic [4:0]             wr_index,
  output logic [DATA_LENGTH-1:0] out0,
  output logic [DATA_LENGTH-1:0] out1,
  output logic [DATA_LENGTH-1:0] out2,
  output logic [DATA_LENGTH-1:0] out3,
  output logic [DATA_LENGTH-1:0] out4,
  output logic [DATA_LENGTH-1:0] out5,
  output logic [DATA_LENGTH-1:0] out6,
  output logic [DATA_LENGTH-1:0] out7,
  output logic [DATA_LENGTH-1:0] out8,
  output logic [DATA_LENGTH-1:0] out9,
  output logic [DATA_LENGTH-1:0] out10,
  output logic [DATA_LENGTH-1:0] out11,
  output logic [DATA_LENGTH-1:0] out12,
  output logic [DATA_LENGTH-1:0] out13,
  output logic [DATA_LENGTH-1:0] out14,
  output logic [DATA_LENGTH-1:0] out15,
  output logic [DATA_LENGTH-1:0] out16,
  output logic [DATA_LENGTH-1:0] out17,
  output logic [DATA_LENGTH-1:0] out18,
  output logic [DATA_LENGTH-1:0] out19,
  output logic [DATA_LENGTH-1:0] out20,
  output logic [DATA_LENGTH-1:0] out21,
  output logic [DATA_LENGTH-1:0] out22,
  output logic [DATA_LENGTH-1:0] out23,
  output logic [DATA_LENGTH-1:0] out24,
  output logic [DATA_LENGTH-1:0] out25,
  output logic [DATA_LENGTH-1:0] out26,
  output logic [DATA_LENGTH-1:0] out27,
  output logic [DATA_LENGTH-1:0] out28,
  output logic [DATA_LENGTH-1:0] out29,
  output logic [DATA_LENGTH-1:0] out30,
  output logic [DATA_LENGTH-1:0] out31
);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] FULL = 1'b1;
  localparam logic [4:0] LAST_SLOT = 5'd31;

  logic [0:0]             state;
  logic [DATA_LENGTH-1:0] slot [32];
  logic                   accept;

  // Both handshake outputs decode the state register only, so in_ready never
  // depends combinationally on in_valid.
  assign in_ready    = (state == FILL);
  assign frame_valid = (state == FULL);
  assign accept      = in_valid & in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FILL;
      wr_index <= '0;
    end else if (flush) begin
      state    <= FILL;
      wr_index <= '0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            wr_index <= wr_index + 5'd1;
            if (wr_index == LAST_SLOT) state <= FULL;
          end
        end
        FULL: begin
          if (frame_ack) state <= FILL;
        end
        default: begin
          state    <= FILL;
          wr_index <= '0;
        end
      endcase
    end
  end

  // NOTE: the holding registers are reset because the consumer may observe
  // them right after reset; flush deliberately leaves them untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) slot[i] <= '0;
    end else if (!flush && accept) begin
      slot[wr_index] <= in_data;
    end
  end

  assign out0  = slot[0];
  assign out1  = slot[1];
  assign out2  = slot[2];
  assign out3  = slot[3];
  assign out4  = slot[4];
  assign out5  = slot[5];
  assign out6  = slot[6];
  assign out7  = slot[7];
  assign out8  = slot[8];
  assign out9  = slot[9];
  assign out10 = slot[10];
  assign out11 = slot[11];
  assign out12 = slot[12];
  assign out13 = slot[13];
  assign out14 = slot[14];
  assign out15 = slot[15];
  assign out16 = slot[16];
  assign out17 = slot[17];
  assign out18 = slot[18];
  assign out19 = slot[19];
  assign out20 = slot[20];
  assign out21 = slot[21];
  assign out22 = slot[22];
  assign out23 = slot[23];
  assign out24 = slot[24];
  assign out25 = slot[25];
  assign out26 = slot[26];
  assign out27 = slot[27];
  assign out28 = slot[28];
  assign out29 = slot[29];
  assign out30 = slot[30];
  assign out31 = slot[31];

endmodule

// File: tb/tb_demux1to32_loader.sv
// Bench for demux1to32_loader: directed frames feed a scoreboard of expected
// frames that a monitor compares when frame_valid rises.
module tb_demux1to32_loader;

  localparam int DL = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DL-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          flush;
  logic          frame_ack;
  logic          frame_valid;
  logic [4:0]    wr_index;
  wire  [DL-1:0] outs [32];

  int checks = 0;
  int errors = 0;
  int frames_pushed = 0;
  int frames_seen = 0;

  logic [32*DL-1:0] exp_q [$];
  logic [32*DL-1:0] exp_frame;
  logic             fv_prev = 1'b0;

  always #5 clk = ~clk;

  demux1to32_loader #(.DATA_LENGTH(DL)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .frame_ack(frame_ack),
    .frame_valid(frame_valid), .wr_index(wr_index),
    .out0(outs[0]),   .out1(outs[1]),   .out2(outs[2]),   .out3(outs[3]),
    .out4(outs[4]),   .out5(outs[5]),   .out6(outs[6]),   .out7(outs[7]),
    .out8(outs[8]),   .out9(outs[9]),   .out10(outs[10]), .out11(outs[11]),
    .out12(outs[12]), .out13(outs[13]), .out14(outs[14]), .out15(outs[15]),
    .out16(outs[16]), .out17(outs[17]), .out18(outs[18]), .out19(outs[19]),
    .out20(outs[20]), .out21(outs[21]), .out22(outs[22]), .out23(outs[23]),
    .out24(outs[24]), .out25(outs[25]), .out26(outs[26]), .out27(outs[27]),
    .out28(outs[28]), .out29(outs[29]), .out30(outs[30]), .out31(outs[31])
  );

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual,
               expected, $time);
    end
  endtask

  // Monitor: one frame comparison at the first cycle of every FULL period.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && frame_valid === 1'b1 && !fv_prev) begin
      frames_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 32'd1, 32'd0);
      end else begin
        exp_frame = exp_q.pop_front();
        for (int k = 0; k < 32; k++)
          check($sformatf("frame%0d_out%0d", frames_seen, k),
                {24'd0, outs[k]}, {24'd0, exp_frame[k*DL +: DL]});
      end
    end
    fv_prev = (frame_valid === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends 32 words base+k; gap inserts one idle cycle between words.
  // Checks that frame_valid rises exactly after the 32nd accept.
  task automatic fill_frame(input logic [7:0] base, input bit gap);
    logic [32*DL-1:0] f;
    for (int k = 0; k < 32; k++) f[k*DL +: DL] = base + 8'(k);
    exp_q.push_back(f);
    frames_pushed++;
    for (int k = 0; k < 32; k++) begin
      in_valid = 1'b1;
      in_data  = base + 8'(k);
      if (k == 31) check("fv_low_before_last", {31'd0, frame_valid}, 32'd0);
      tick();
      if (gap && k != 31) begin
        in_valid = 1'b0;
        in_data  = 8'hEE;
        tick();
      end
    end
    in_valid = 1'b0;
    check("fv_after_last", {31'd0, frame_valid}, 32'd1);
    check("ready_low_full", {31'd0, in_ready}, 32'd0);
    check("idx_wrapped", {27'd0, wr_index}, 32'd0);
  endtask

  task automatic ack_frame();
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    check("ack_fv_low", {31'd0, frame_valid}, 32'd0);
    check("ack_ready_high", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b1; in_data = '0; in_valid = 1'b0; flush = 1'b0; frame_ack = 1'b0;

    // Asynchronous reset between clock edges.
    #3 rst_n = 1'b0;
    #1;
    check("rst_out0", {24'd0, outs[0]}, 32'd0);
    check("rst_out31", {24'd0, outs[31]}, 32'd0);
    check("rst_idx", {27'd0, wr_index}, 32'd0);
    check("rst_fv", {31'd0, frame_valid}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rst_ready", {31'd0, in_ready}, 32'd1);

    // Back-to-back fill with data k+1.
    fill_frame(8'd1, 1'b0);

    // Hold: words offered in FULL are ignored.
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_data  = 8'hAA;
      tick();
      check("hold_ready", {31'd0, in_ready}, 32'd0);
      check("hold_fv", {31'd0, frame_valid}, 32'd1);
      if (c == 9) begin
        check("hold_idx", {27'd0, wr_index}, 32'd0);
        check("hold_out0", {24'd0, outs[0]}, 32'd1);
        check("hold_out31", {24'd0, outs[31]}, 32'd32);
      end
    end
    in_valid = 1'b0;
    ack_frame();
    check("ack_idx", {27'd0, wr_index}, 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    tick();
    in_valid = 1'b0;
    check("next_out0", {24'd0, outs[0]}, 32'h55);
    check("next_out1_kept", {24'd0, outs[1]}, 32'd2);
    check("next_idx", {27'd0, wr_index}, 32'd1);

    // Flush without a word, then gapped fill.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush0_idx", {27'd0, wr_index}, 32'd0);
    check("flush0_out0_kept", {24'd0, outs[0]}, 32'h55);
    fill_frame(8'd1, 1'b1);
    // ack held high continuously: release after exactly one cycle
    frame_ack = 1'b1;
    tick();
    check("ackhold_fv", {31'd0, frame_valid}, 32'd0);
    check("ackhold_ready", {31'd0, in_ready}, 32'd1);
    frame_ack = 1'b0;

    // Flush mid-frame with a word offered in the same cycle.
    for (int k = 0; k < 12; k++) begin
      in_valid = 1'b1;
      in_data  = 8'h80 + 8'(k);
      tick();
    end
    check("pre_flush_idx", {27'd0, wr_index}, 32'd12);
    flush    = 1'b1;
    in_data  = 8'h77;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_idx", {27'd0, wr_index}, 32'd0);
    check("flush_ready", {31'd0, in_ready}, 32'd1);
    check("flush_out0", {24'd0, outs[0]}, 32'h80);
    check("flush_out11", {24'd0, outs[11]}, 32'h8B);
    check("flush_out12_discard", {24'd0, outs[12]}, 32'd13);
    fill_frame(8'hC0, 1'b0);
    ack_frame();

    // Reset mid-frame.
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1;
      in_data  = 8'h20 + 8'(k);
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mrst_out0", {24'd0, outs[0]}, 32'd0);
    check("mrst_out19", {24'd0, outs[19]}, 32'd0);
    check("mrst_out31", {24'd0, outs[31]}, 32'd0);
    check("mrst_idx", {27'd0, wr_index}, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 15; c++) tick();
    check("mrst_no_fv", {31'd0, frame_valid}, 32'd0);
    fill_frame(8'hE0, 1'b0);
    ack_frame();

    tick(); tick();
    check("frames_seen", frames_seen, frames_pushed);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/demux1to32_loader.md
# demux1to32_loader

Sequential 1-to-32 sample distributor for the 16-point FFT datapath: accepts a serial stream of words over a valid/ready handshake and writes them into 32 parallel holding registers (16 complex points, re/im interleaved). When all 32 words are captured it presents the frame to the FFT core and holds it until acknowledged. It is the write side of the core's 32-to-1 readout mux.

## Interface
- DATA_LENGTH, 8, width of each sample word
- clk  in  1  rising-edge clock, sole clock domain
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  DATA_LENGTH  serial input word
- in_valid  in  1  in_data is valid this cycle
- in_ready  out  1  block accepts a word this cycle
- flush  in  1  synchronous abort of current frame
- frame_ack  in  1  consumer has taken the held frame
- frame_valid  out  1  out0..out31 hold a complete frame
- wr_index  out  5  slot written by the next accepted word
- out0 … out31  out  DATA_LENGTH each  holding registers; word k of the frame lands in outk

## Operation
- Accept = in_valid & in_ready, sampled on the rising edge of clk.
- Two states: FILL and FULL.
- FILL: in_ready=1, frame_valid=0. On accept, out[wr_index] <= in_data and wr_index increments. If the accept happens with wr_index==31, wr_index wraps to 0 and the state goes to FULL.
- FULL: in_ready=0, frame_valid=1, out0..out31 frozen. in_valid is ignored. When frame_ack=1, the state returns to FILL and wr_index stays 0.
- frame_ack in FILL has no effect.
- flush=1 has highest priority in either state:
  - state goes to FILL and wr_index goes to 0;
  - any word presented in the same cycle is discarded;
  - out0..out31 keep their current values and are not cleared.
- Writes go only to the addressed register. All other outk hold their values.
- No arithmetic on the data path. wr_index is a 5-bit counter that wraps modulo 32.
- Reset (rst_n=0, asynchronous): state=FILL, wr_index=0, frame_valid=0, in_ready=1 after release, out0..out31=0.
- Reset mid-frame: partial frame lost. No frame_valid is produced for it.

## Timing
- in_ready is a registered state decode. It does not depend combinationally on in_valid.
- Word k is visible on outk the cycle after its accept.
- frame_valid rises in the cycle after the 32nd accept. At that point out0..out31 already hold the complete frame.
- frame_ack sampled high in FULL:
  - frame_valid=0 and in_ready=1 from the next cycle;
  - the first word of the next frame can be accepted that cycle.
- frame_ack held high continuously releases FULL after exactly one cycle. Minimum frame period is 33 cycles.
- in_ready goes low in the cycle after the 32nd accept. No word is ever accepted while frame_valid=1.
- flush takes effect at the edge where it is sampled. in_ready=1 and wr_index=0 from the next cycle.

## Test plan
- **Reset values:** assert rst_n=0 mid-cycle, without a clock edge → out0..out31=0, wr_index=0, frame_valid=0 immediately. After release, in_ready=1.
- **Back-to-back fill:** in_valid=1 continuously with in_data=k+1 for k=0..31 (DATA_LENGTH=8) → outk=k+1. frame_valid rises in cycle 33. in_ready=0 from cycle 33 until ack.
- **Hold until ack:** keep in_valid=1 with data 0xAA during 10 FULL cycles → outputs unchanged and no accept. frame_ack pulse → next cycle frame_valid=0, in_ready=1, wr_index=0. The next word 0x55 lands in out0.
- **Gapped input:** toggle in_valid every other cycle over 32 words → same final contents as the back-to-back case. frame_valid rises the cycle after the 32nd accept (cycle 64).
- **Flush mid-frame:** after 12 accepts, assert flush together with in_valid=1 and data 0x77 → word discarded, wr_index=0, out0..out11 keep old data. The next 32 words complete a fresh frame.
- **Reset mid-frame:** after 20 accepts, pulse rst_n low → all outputs 0, no frame_valid. Refilling 32 words produces a normal frame.
